// File: rtl/convolutor_job_sequencer.sv
// Job sequencer around the convolutor: loads Y memory, pulses start, waits for done
// under a watchdog, then streams Z memory out over a valid/ready handshake.
module convolutor_job_sequencer #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int X_SIZE     = 5,
   parameter int TIMEOUT    = 1023
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    job_valid_i,
   output logic                    job_ready_o,
   input  logic [ADDR_WIDTH-1:0]   job_size_i,
   input  logic                    y_valid_i,
   output logic                    y_ready_o,
   input  logic [DATA_WIDTH-1:0]   y_data_i,
   output logic                    memY_wr_en_o,
   output logic [ADDR_WIDTH-1:0]   memY_wr_addr_o,
   output logic [DATA_WIDTH-1:0]   memY_wr_data_o,
   output logic                    conv_start_o,
   output logic [ADDR_WIDTH-1:0]   conv_sizeY_o,
   input  logic                    conv_done_i,
   output logic [ADDR_WIDTH:0]     memZ_rd_addr_o,
   input  logic [2*DATA_WIDTH-1:0] memZ_rd_data_i,
   output logic                    z_valid_o,
   input  logic                    z_ready_i,
   output logic [2*DATA_WIDTH-1:0] z_data_o,
   output logic                    z_last_o,
   output logic                    busy_o,
   output logic                    err_o
);
   localparam int ZW = ADDR_WIDTH + 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
   localparam logic [ZW-1:0]         ONE_Z = 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_Y    = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      RD_ADDR   = 3'd4,
      RD_WAIT   = 3'd5,
      OUT       = 3'd6
   } state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   size_q, ycnt;
   logic [ZW-1:0]           zlen, zcnt, rd_addr_q;
   logic [WW-1:0]           wdog;
   logic [2*DATA_WIDTH-1:0] zdata_q;
   logic                    zvalid_q, zlast_q;
   logic                    timeout, done_ok;

   // The watchdog is zero only in the first WAIT_DONE cycle, where done is not trusted yet.
   assign timeout = (wdog == WW'(TIMEOUT));
   assign done_ok = conv_done_i && (wdog != '0);

   always_comb begin
      state_nxt = state;
      err_o     = 1'b0;
      case (state)
         IDLE: begin
            if (job_valid_i) begin
               if (job_size_i == '0) err_o = 1'b1;
               else                  state_nxt = LOAD_Y;
            end
         end
         LOAD_Y:    if (y_valid_i && (ycnt == size_q - ONE_A)) state_nxt = START;
         START:     state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (done_ok) begin
               state_nxt = RD_ADDR;
            end else if (timeout) begin
               err_o     = 1'b1;
               state_nxt = IDLE;
            end
         end
         RD_ADDR:   state_nxt = RD_WAIT;
         RD_WAIT:   state_nxt = OUT;
         OUT:       if (z_ready_i) state_nxt = zlast_q ? IDLE : RD_ADDR;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         size_q    <= '0;
         zlen      <= '0;
         ycnt      <= '0;
         zcnt      <= '0;
         rd_addr_q <= '0;
         wdog      <= '0;
         zdata_q   <= '0;
         zvalid_q  <= 1'b0;
         zlast_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (job_valid_i && (job_size_i != '0)) begin
                  size_q <= job_size_i;
                  zlen   <= ZW'(job_size_i) + ZW'(X_SIZE - 1);
                  ycnt   <= '0;
                  zcnt   <= '0;
               end
            end
            LOAD_Y:    if (y_valid_i) ycnt <= ycnt + ONE_A;
            START:     wdog <= '0;
            WAIT_DONE: begin
               if (!timeout) wdog <= wdog + WW'(1);
               if (done_ok)  zcnt <= '0;
            end
            RD_ADDR:   rd_addr_q <= zcnt;
            // Z memory has one cycle of read latency, so data is valid during RD_WAIT.
            RD_WAIT: begin
               zdata_q  <= memZ_rd_data_i;
               zvalid_q <= 1'b1;
               zlast_q  <= (zcnt == zlen - ONE_Z);
            end
            OUT: begin
               if (z_ready_i) begin
                  zvalid_q <= 1'b0;
                  zlast_q  <= 1'b0;
                  if (!zlast_q) zcnt <= zcnt + ONE_Z;
               end
            end
            default: ;
         endcase
      end
   end

   assign job_ready_o    = (state == IDLE);
   assign busy_o         = (state != IDLE);
   assign y_ready_o      = (state == LOAD_Y);
   assign memY_wr_en_o   = (state == LOAD_Y) && y_valid_i;
   assign memY_wr_addr_o = ycnt;
   assign memY_wr_data_o = memY_wr_en_o ? y_data_i : '0;
   assign conv_start_o   = (state == START);
   assign conv_sizeY_o   = size_q;
   assign memZ_rd_addr_o = (state == RD_ADDR) ? zcnt : rd_addr_q;
   assign z_valid_o      = zvalid_q;
   assign z_data_o       = zdata_q;
   assign z_last_o       = zlast_q;

endmodule

// File: tb/tb_convolutor_job_sequencer.sv
// Directed bench for convolutor_job_sequencer: a default-timeout instance for the data
// path and a TIMEOUT=15 instance for the watchdog scenarios.
module tb_convolutor_job_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        job_valid = 1'b0, t_job_valid = 1'b0;
   logic [4:0]  job_size = '0;
   logic        y_valid = 1'b0;
   logic [7:0]  y_data = '0;
   logic        conv_done = 1'b0;
   logic        z_ready = 1'b1;
   logic [15:0] zrd = '0;

   logic        job_ready, y_ready, wr_en, conv_start, z_valid, z_last, busy, err;
   logic [4:0]  wr_addr, size_y;
   logic [7:0]  wr_data;
   logic [5:0]  rd_addr;
   logic [15:0] z_data;

   logic        t_job_ready, t_y_ready, t_wr_en, t_conv_start, t_z_valid, t_z_last, t_busy, t_err;
   logic [4:0]  t_wr_addr, t_size_y;
   logic [7:0]  t_wr_data;
   logic [5:0]  t_rd_addr;
   logic [15:0] t_z_data;

   convolutor_job_sequencer dut (
      .clk(clk), .rst_n(rst_n), .job_valid_i(job_valid), .job_ready_o(job_ready),
      .job_size_i(job_size), .y_valid_i(y_valid), .y_ready_o(y_ready), .y_data_i(y_data),
      .memY_wr_en_o(wr_en), .memY_wr_addr_o(wr_addr), .memY_wr_data_o(wr_data),
      .conv_start_o(conv_start), .conv_sizeY_o(size_y), .conv_done_i(conv_done),
      .memZ_rd_addr_o(rd_addr), .memZ_rd_data_i(zrd), .z_valid_o(z_valid), .z_ready_i(z_ready),
      .z_data_o(z_data), .z_last_o(z_last), .busy_o(busy), .err_o(err));

   convolutor_job_sequencer #(.TIMEOUT(15)) dut_t (
      .clk(clk), .rst_n(rst_n), .job_valid_i(t_job_valid), .job_ready_o(t_job_ready),
      .job_size_i(job_size), .y_valid_i(y_valid), .y_ready_o(t_y_ready), .y_data_i(y_data),
      .memY_wr_en_o(t_wr_en), .memY_wr_addr_o(t_wr_addr), .memY_wr_data_o(t_wr_data),
      .conv_start_o(t_conv_start), .conv_sizeY_o(t_size_y), .conv_done_i(conv_done),
      .memZ_rd_addr_o(t_rd_addr), .memZ_rd_data_i(zrd), .z_valid_o(t_z_valid), .z_ready_i(z_ready),
      .z_data_o(t_z_data), .z_last_o(t_z_last), .busy_o(t_busy), .err_o(t_err));

   always #5 clk = ~clk;

   logic [15:0] zmem [0:63];
   logic [4:0]  wa [$];
   logic [7:0]  wd [$];
   logic [15:0] zq [$];
   logic        lq [$];
   int          start_cnt = 0, err_cnt = 0, stab_bad = 0, t_err_cnt = 0, t_z_cnt = 0;
   logic        hold_pend = 1'b0, hold_last = 1'b0;
   logic [15:0] hold_data = '0;
   int          total = 0, bad = 0;

   // Memory models and transaction logging.
   always @(posedge clk) begin
      zrd <= zmem[rd_addr];
      if (wr_en) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
      end
      if (conv_start) start_cnt <= start_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (z_valid && z_ready) begin
         zq.push_back(z_data);
         lq.push_back(z_last);
      end
      if (hold_pend && (!z_valid || z_data !== hold_data || z_last !== hold_last))
         stab_bad <= stab_bad + 1;
      hold_pend <= z_valid && !z_ready;
      hold_data <= z_data;
      hold_last <= z_last;
      if (t_err) t_err_cnt <= t_err_cnt + 1;
      if (t_z_valid && z_ready) t_z_cnt <= t_z_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wa.delete(); wd.delete(); zq.delete(); lq.delete();
   endtask

   task automatic issue_job(input int size, input bit to_t);
      job_size = 5'(size);
      if (to_t) t_job_valid = 1'b1; else job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      t_job_valid = 1'b0;
   endtask

   task automatic feed_y(input int n, input int base, input int step, input int gap_mod);
      for (int i = 0; i < n; i++) begin
         if (gap_mod != 0 && (i % gap_mod) == 1) begin
            y_valid = 1'b0;
            tick();
            tick();
         end
         y_valid = 1'b1;
         y_data  = 8'(base + i * step);
         tick();
      end
      y_valid = 1'b0;
   endtask

   task automatic run_until_z(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (zq.size() < n && k < budget) begin
         tick();
         k++;
      end
      ok = (zq.size() >= n);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({job_ready, busy, y_ready, wr_en, conv_start, z_valid, z_last, err} !== 8'b1000_0000) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=10000000",
                  {job_ready, busy, y_ready, wr_en, conv_start, z_valid, z_last, err});
      end
      total++;
      if ({wr_addr, wr_data, size_y, rd_addr, z_data} !== 40'd0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0", {wr_addr, wr_data, size_y, rd_addr, z_data});
      end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_nominal();
      bit ok;
      int e0;
      for (int i = 0; i < 8; i++) zmem[i] = 16'(i);
      clear_logs();
      e0 = err_cnt;
      issue_job(4, 1'b0);
      total++;
      if ({y_ready, busy, job_ready} !== 3'b110) begin
         bad++; $display("FAIL nom_load_state got=%b want=110", {y_ready, busy, job_ready});
      end
      feed_y(4, 1, 1, 0);
      total++;
      if (conv_start !== 1'b1 || size_y !== 5'd4) begin
         bad++; $display("FAIL nom_start got start=%b size=%0d want start=1 size=4", conv_start, size_y);
      end
      tick();
      total++;
      if (conv_start !== 1'b0) begin
         bad++; $display("FAIL nom_start_pulse got=%b want=0", conv_start);
      end
      for (int i = 0; i < 19; i++) begin
         job_valid = (i == 5);
         job_size  = 5'd0;
         tick();
      end
      job_valid = 1'b0;
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      run_until_z(8, 200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL nom_z_count got=%0d want=8", zq.size()); end
      total++;
      if (wa.size() != 4) begin bad++; $display("FAIL nom_y_writes got=%0d want=4", wa.size()); end
      for (int i = 0; i < wa.size() && i < 4; i++) begin
         total++;
         if (wa[i] !== 5'(i) || wd[i] !== 8'(i + 1)) begin
            bad++; $display("FAIL nom_y_wr%0d got a=%0d d=%0d want a=%0d d=%0d", i, wa[i], wd[i], i, i + 1);
         end
      end
      for (int i = 0; i < zq.size() && i < 8; i++) begin
         total++;
         if (zq[i] !== 16'(i) || lq[i] !== (i == 7)) begin
            bad++; $display("FAIL nom_z%0d got d=%0d l=%b want d=%0d l=%b", i, zq[i], lq[i], i, i == 7);
         end
      end
      total++;
      if (job_ready !== 1'b1 || busy !== 1'b0 || err_cnt != e0) begin
         bad++; $display("FAIL nom_end got ready=%b busy=%b errs=%0d want 1 0 0", job_ready, busy, err_cnt - e0);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int s0, k;
      for (int i = 0; i < 8; i++) zmem[i] = 16'h0100 + 16'(i);
      clear_logs();
      s0 = stab_bad;
      issue_job(4, 1'b0);
      feed_y(4, 9, 2, 0);
      repeat (3) tick();
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      k = 0;
      while (!(z_valid && zq.size() == 2) && k < 50) begin tick(); k++; end
      total++;
      if (k >= 50) begin bad++; $display("FAIL bp_reach_word2 got=timeout want=word2"); end
      z_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (z_valid !== 1'b1 || z_data !== 16'h0102) begin
            bad++; $display("FAIL bp_hold%0d got v=%b d=%h want v=1 d=0102", c, z_valid, z_data);
         end
      end
      z_ready = 1'b1;
      run_until_z(8, 100, ok);
      total++;
      if (!ok || stab_bad != s0) begin
         bad++; $display("FAIL bp_stream got n=%0d unstable=%0d want n=8 unstable=0", zq.size(), stab_bad - s0);
      end
      for (int i = 0; i < zq.size() && i < 8; i++) begin
         total++;
         if (zq[i] !== 16'h0100 + 16'(i)) begin
            bad++; $display("FAIL bp_z%0d got=%h want=%h", i, zq[i], 16'h0100 + 16'(i));
         end
      end
   endtask

   task automatic test_zero_size();
      int e0, s0;
      clear_logs();
      e0 = err_cnt;
      s0 = start_cnt;
      job_size  = 5'd0;
      job_valid = 1'b1;
      #1;
      total++;
      if (err !== 1'b1 || job_ready !== 1'b1) begin
         bad++; $display("FAIL zero_err got err=%b ready=%b want 1 1", err, job_ready);
      end
      tick();
      job_valid = 1'b0;
      #1;
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL zero_after got err=%b busy=%b want 0 0", err, busy);
      end
      repeat (4) tick();
      total++;
      if (err_cnt - e0 != 1 || start_cnt != s0 || wa.size() != 0) begin
         bad++; $display("FAIL zero_side got errs=%0d starts=%0d writes=%0d want 1 0 0",
                         err_cnt - e0, start_cnt - s0, wa.size());
      end
   endtask

   task automatic test_timeout();
      int n, e0, z0;
      e0 = t_err_cnt;
      z0 = t_z_cnt;
      issue_job(2, 1'b1);
      feed_y(2, 4, 1, 0);
      total++;
      if (t_conv_start !== 1'b1) begin bad++; $display("FAIL to_start got=%b want=1", t_conv_start); end
      tick();
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      n = 2;
      while (!t_err && n < 60) begin tick(); n++; end
      total++;
      if (n != 16 || t_job_ready !== 1'b0) begin
         bad++; $display("FAIL to_err_cycle got=%0d ready=%b want=16 ready=0", n, t_job_ready);
      end
      tick();
      total++;
      if (t_job_ready !== 1'b1 || t_busy !== 1'b0 || t_err !== 1'b0) begin
         bad++; $display("FAIL to_after got ready=%b busy=%b err=%b want 1 0 0", t_job_ready, t_busy, t_err);
      end
      total++;
      if (t_err_cnt - e0 != 1 || t_z_cnt != z0) begin
         bad++; $display("FAIL to_side got errs=%0d zwords=%0d want 1 0", t_err_cnt - e0, t_z_cnt - z0);
      end
   endtask

   task automatic test_done_tie();
      int n, e0, z0;
      e0 = t_err_cnt;
      z0 = t_z_cnt;
      issue_job(2, 1'b1);
      feed_y(2, 4, 1, 0);
      n = 0;
      while (n < 16) begin tick(); n++; end
      conv_done = 1'b1;
      #1;
      total++;
      if (t_err !== 1'b0) begin bad++; $display("FAIL tie_err got=%b want=0", t_err); end
      tick();
      conv_done = 1'b0;
      n = 0;
      while (t_busy && n < 100) begin tick(); n++; end
      total++;
      if (t_err_cnt != e0 || t_z_cnt - z0 != 6 || t_busy !== 1'b0) begin
         bad++; $display("FAIL tie_result got errs=%0d zwords=%0d busy=%b want 0 6 0",
                         t_err_cnt - e0, t_z_cnt - z0, t_busy);
      end
   endtask

   task automatic test_reset_midstream();
      bit ok;
      for (int i = 0; i < 8; i++) zmem[i] = 16'h0200 + 16'(i);
      issue_job(4, 1'b0);
      y_valid = 1'b1; y_data = 8'h11; tick();
      y_data = 8'h22; tick();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({job_ready, busy, y_ready, wr_en, wr_addr} !== 9'b1_0000_0000) begin
         bad++; $display("FAIL rst_mid got=%b want=100000000", {job_ready, busy, y_ready, wr_en, wr_addr});
      end
      #1 rst_n = 1'b1;
      y_valid = 1'b0;
      tick();
      clear_logs();
      issue_job(1, 1'b0);
      feed_y(1, 8'h5A, 0, 0);
      total++;
      if (wa.size() != 1 || wa[0] !== 5'd0 || wd[0] !== 8'h5A) begin
         bad++; $display("FAIL rst_next_addr got n=%0d a=%0d want n=1 a=0", wa.size(), wa.size() ? wa[0] : 5'd31);
      end
      repeat (3) tick();
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      run_until_z(5, 100, ok);
      total++;
      if (!ok || lq[4] !== 1'b1 || zq[4] !== 16'h0204 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_next_job got n=%0d want n=5 last on word 4", zq.size());
      end
   endtask

   task automatic test_max_size();
      bit ok;
      int bad_w, bad_z;
      for (int i = 0; i < 64; i++) zmem[i] = 16'hA000 + 16'(i);
      clear_logs();
      issue_job(31, 1'b0);
      feed_y(31, 3, 7, 3);
      total++;
      if (conv_start !== 1'b1 || size_y !== 5'd31) begin
         bad++; $display("FAIL max_start got start=%b size=%0d want 1 31", conv_start, size_y);
      end
      repeat (5) tick();
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      run_until_z(35, 400, ok);
      bad_w = 0;
      for (int i = 0; i < wa.size(); i++)
         if (wa[i] !== 5'(i) || wd[i] !== 8'(3 + i * 7)) bad_w++;
      total++;
      if (wa.size() != 31 || bad_w != 0) begin
         bad++; $display("FAIL max_y_writes got n=%0d wrong=%0d want n=31 wrong=0", wa.size(), bad_w);
      end
      bad_z = 0;
      for (int i = 0; i < zq.size(); i++)
         if (zq[i] !== 16'hA000 + 16'(i) || lq[i] !== (i == 34)) bad_z++;
      total++;
      if (!ok || zq.size() != 35 || bad_z != 0) begin
         bad++; $display("FAIL max_z_words got n=%0d wrong=%0d want n=35 wrong=0", zq.size(), bad_z);
      end
      total++;
      if (rd_addr !== 6'd34) begin bad++; $display("FAIL max_last_addr got=%0d want=34", rd_addr); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) zmem[i] = '0;
      test_reset();
      test_nominal();
      test_back_to_back();
      test_zero_size();
      test_timeout();
      test_done_tie();
      test_reset_midstream();
      test_max_size();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/convolutor_job_sequencer.md
Name: convolutor_job_sequencer

Overview:
Host-side controller that runs one convolution job end to end around the convolutor datapath.
- Accepts a job descriptor (Y length) and streams Y samples into Y memory.
- Pulses the convolutor start, waits for done or a watchdog timeout.
- Reads Z memory back and streams the results out over a valid/ready handshake.
- Sits between the host bus adapter and the convolutor plus its Y/Z memories.

Parameters:
ADDR_WIDTH, 5, Y address width; Z address is ADDR_WIDTH+1.
DATA_WIDTH, 8, Y sample width; Z word is 2*DATA_WIDTH.
X_SIZE, 5, fixed X kernel length held in the convolutor ROM.
TIMEOUT, 1023, maximum cycles in WAIT_DONE before the error abort.

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
job_valid_i  in  1  job descriptor valid
job_ready_o  out  1  sequencer can accept a job
job_size_i  in  ADDR_WIDTH  Y length (sizeY)
y_valid_i  in  1  Y sample valid
y_ready_o  out  1  Y sample accepted
y_data_i  in  DATA_WIDTH  Y sample
memY_wr_en_o  out  1  Y memory write enable
memY_wr_addr_o  out  ADDR_WIDTH  Y memory write address
memY_wr_data_o  out  DATA_WIDTH  Y memory write data
conv_start_o  out  1  convolutor start pulse
conv_sizeY_o  out  ADDR_WIDTH  latched job size to the convolutor
conv_done_i  in  1  convolutor done flag
memZ_rd_addr_o  out  ADDR_WIDTH+1  Z memory read address (1-cycle read latency)
memZ_rd_data_i  in  2*DATA_WIDTH  Z memory read data
z_valid_o  out  1  output word valid
z_ready_i  in  1  downstream ready
z_data_o  out  2*DATA_WIDTH  output Z word
z_last_o  out  1  final Z word of the job
busy_o  out  1  job in progress
err_o  out  1  one-cycle error pulse (zero size or timeout)

Behaviour:
- Reset values: every output is 0, except job_ready_o=1. State=IDLE; all counters and registers are 0. Reset is legal in any state and aborts the job immediately; partial memory contents are not cleared.
- Handshakes: a transfer occurs on valid&ready at the clock edge. The sequencer holds z_valid_o/z_data_o/z_last_o stable until z_ready_i.
- IDLE:
  - job_ready_o=1.
  - On job accept with job_size_i=0: err_o=1 for one cycle, stay in IDLE.
  - Otherwise latch size into conv_sizeY_o, compute zlen=size+X_SIZE-1 (ADDR_WIDTH+1 bits, no overflow), clear counters, go to LOAD_Y.
- LOAD_Y:
  - y_ready_o=1.
  - Each accepted sample drives memY_wr_en_o=1 combinationally, with memY_wr_addr_o=ycnt and memY_wr_data_o=y_data_i. ycnt increments after each write.
  - Accepting sample number size-1 moves to START.
  - Stalls indefinitely while y_valid_i=0.
- START: conv_start_o=1 for exactly one cycle, clear the watchdog, go to WAIT_DONE.
- WAIT_DONE:
  - conv_done_i is ignored in the first cycle after START.
  - conv_done_i=1 (level) goes to RD_ADDR with zcnt=0.
  - If the watchdog reaches TIMEOUT: err_o pulse, go to IDLE.
- RD_ADDR: memZ_rd_addr_o=zcnt, go to RD_WAIT.
- RD_WAIT: on the next edge capture memZ_rd_data_i into the z_data_o register, set z_valid_o=1 and z_last_o=(zcnt==zlen-1), go to OUT.
- OUT: on z_ready_i, clear z_valid_o and z_last_o. If last, go to IDLE; else increment zcnt and go to RD_ADDR.
- Throughput: at most one Z word per 3 cycles.
- busy_o=1 in every state except IDLE. job_ready_o=0 whenever busy_o=1. job_valid_i while busy is ignored, not queued.
- Simultaneous events:
  - conv_done_i and the timeout in the same cycle: done wins.
  - z_ready_i held high: the word is accepted in the first OUT cycle.
- memZ_rd_addr_o holds its last value outside RD_ADDR. memY_wr_en_o=0 outside LOAD_Y.

Test Plan:
- Reset mid-stream: assert rst_n=0 in LOAD_Y after 2 samples -> all outputs 0 and job_ready_o=1 asynchronously; the next job starts at memY_wr_addr_o=0.
- Nominal: job size=4, Y=1,2,3,4, conv_done_i 20 cycles after start, memZ preloaded 0..7 -> 4 Y writes at addr 0..3, one conv_start_o pulse with conv_sizeY_o=4, 8 Z words 0..7 with z_last_o on word 7, then IDLE.
- Back-pressure: hold z_ready_i=0 for 5 cycles on word 2 -> z_data_o and z_valid_o stable throughout, no skipped or duplicated words.
- Zero size: job_size_i=0 -> single err_o pulse, busy_o stays 0, no memY write, no start.
- Timeout: TIMEOUT=15, conv_done_i never asserted -> err_o pulse 15 cycles into WAIT_DONE, no Z reads, job_ready_o=1 next cycle.
- Max size plus Y gaps: size=31 with random y_valid_i gaps -> 31 writes at addr 0..30, zlen=35, last Z read address 34 with z_last_o set.
